uart_mmio_fifo: RTL and testbench

Buffered memory-mapped UART bridge between the CPU's execute/memory stage and the UART transceiver, replacing the unbuffered UART decode path. It holds a transmit FIFO and a receive FIFO, decodes the 0x8xxxxxxx I/O region, and returns registered read data in the write-back stage, one cycle after the access. The CPU can then send bursts of bytes without polling per byte, and received bytes are not lost while software is busy.

---
 rtl/uart_mmio_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_mmio_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: buffered memory-mapped UART bridge.
//
// Decodes the 0x8xxxxxxx I/O region from the Y stage and returns load data registered for Z.
// A transmit FIFO and a receive FIFO sit between the CPU and the UART transceiver.
//
// Register map (offset = req_addr[7:0]):
//   0x00 STATUS  (R) bit0 rx_nonempty, bit1 tx_notfull, bit2 tx overflow sticky,
//                    [11:8] rx_count, [19:16] tx_count
//   0x04 RX_DATA (R) RX head; pops RX. Reads 0 and does not pop when RX is empty.
//   0x08 TX_DATA (W) pushes req_wdata[7:0]. Dropped and sticky overflow set when TX is full.
//   0x0C CTRL    (W) bit0 flushes both FIFOs, bit1 clears the overflow sticky bit
//   0x10 CYCLES  (R) free-running cycle counter  (only with UART_MMIO_CYCLE_CNT_EN)
//   0x14 CYC_CLR (W) zeroes the cycle counter     (only with UART_MMIO_CYCLE_CNT_EN)
// Every other offset reads 0 and ignores writes.
//
// Build option: define UART_MMIO_CYCLE_CNT_EN to add the cycle counter.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   stall               pipeline stall; blocks CPU accesses and holds rd_data
//   req_addr/wdata/we/re  Y-stage access
//   rd_data             registered load data for Z
//   tx_data/valid/ready to the UART transmitter
//   rx_data/valid/ready from the UART receiver

module uart_mmio_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        req_we,
  input  logic        req_re,
  output logic [31:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned PtrW  = DEPTH_LOG2 + 1;

  localparam logic [7:0] OffStatus = 8'h00;
  localparam logic [7:0] OffRxData = 8'h04;
  localparam logic [7:0] OffTxData = 8'h08;
  localparam logic [7:0] OffCtrl   = 8'h0C;
`ifdef UART_MMIO_CYCLE_CNT_EN
  localparam logic [7:0] OffCnt    = 8'h10;
  localparam logic [7:0] OffCntClr = 8'h14;
`endif

  logic [7:0] tx_mem [Depth];
  logic [7:0] rx_mem [Depth];

  logic [PtrW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic            ovf_q;
  logic [31:0]     rd_data_q;

  logic            sel;
  logic [7:0]      offset;
  logic            unused_addr;
  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic [PtrW-1:0] tx_count, rx_count;
  logic            tx_pop, tx_push, rx_pop, rx_push;
  logic            wr_tx, rd_rx, ctrl_wr, flush, ovf_set, ovf_clr;
  logic [31:0]     status;
  logic [31:0]     rd_mux;

  assign sel         = (req_addr[31:28] == 4'h8) & ~stall;
  assign offset      = req_addr[7:0];
  assign unused_addr = ^req_addr[27:8];

  // Same MSB with equal low bits is empty; differing MSB with equal low bits is full.
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign tx_full  = (tx_wr_q[PtrW-1] != tx_rd_q[PtrW-1]) &&
                    (tx_wr_q[PtrW-2:0] == tx_rd_q[PtrW-2:0]);
  assign rx_full  = (rx_wr_q[PtrW-1] != rx_rd_q[PtrW-1]) &&
                    (rx_wr_q[PtrW-2:0] == rx_rd_q[PtrW-2:0]);
  assign tx_count = tx_wr_q - tx_rd_q;
  assign rx_count = rx_wr_q - rx_rd_q;

  // UART side
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rd_q[DEPTH_LOG2-1:0]];
  assign rx_ready = ~rx_full;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & rx_ready;

  // CPU side
  assign wr_tx   = sel & req_we & (offset == OffTxData);
  assign rd_rx   = sel & req_re & (offset == OffRxData);
  assign ctrl_wr = sel & req_we & (offset == OffCtrl);
  assign flush   = ctrl_wr & req_wdata[0];
  assign ovf_clr = ctrl_wr & req_wdata[1];
  // A full TX FIFO still accepts a write when the UART drains a byte in the same cycle.
  assign tx_push = wr_tx & (~tx_full | tx_pop);
  assign ovf_set = wr_tx & tx_full & ~tx_pop;
  // Empty RX never pops, even if the UART pushes in the same cycle.
  assign rx_pop  = rd_rx & ~rx_empty;

  always_comb begin
    status              = '0;
    status[0]           = ~rx_empty;
    status[1]           = ~tx_full;
    status[2]           = ovf_q;
    status[8 +: PtrW]   = rx_count;
    status[16 +: PtrW]  = tx_count;
  end

`ifdef UART_MMIO_CYCLE_CNT_EN
  logic [31:0] cyc_cnt_q;
  logic        cnt_clr;

  assign cnt_clr = sel & req_we & (offset == OffCntClr);

  // Free-running, counts through stalls and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cyc_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
    end
  end
`else
  // No counter: 0x10 and 0x14 decode as unmapped offsets.
`endif

  always_comb begin
    rd_mux = '0;
    case (offset)
      OffStatus: rd_mux = status;
      OffRxData: rd_mux = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd_q[DEPTH_LOG2-1:0]]};
`ifdef UART_MMIO_CYCLE_CNT_EN
      OffCnt:    rd_mux = cyc_cnt_q;
`endif
      default:   rd_mux = '0;
    endcase
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[DEPTH_LOG2-1:0]] <= req_wdata;
    if (rx_push) rx_mem[rx_wr_q[DEPTH_LOG2-1:0]] <= rx_data;
  end

  // Flush overrides any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  // Non-load cycles return 0; a stall freezes the Z-stage value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (!stall) begin
      rd_data_q <= (sel && req_re) ? rd_mux : 32'd0;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_uart_mmio_fifo.sv
module tb_uart_mmio_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_we = 1'b0;
  logic        req_re = 1'b0;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  uart_mmio_fifo #(.DEPTH_LOG2(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_we   (req_we),
    .req_re   (req_re),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: byte queues plus the few architectural bits.
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_rd = '0;
  logic [31:0] m_cnt = '0;
  logic [7:0]  got_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        re;
    logic        stall;
    logic        rxv;
    logic [7:0]  rxd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic [31:0] a, input logic [7:0] wd, input logic we,
                               input logic re, input logic st, input logic rxv,
                               input logic [7:0] rxd, input logic [31:0] exp_rd);
    vec_t v;
    v.addr = a; v.wdata = wd; v.we = we; v.re = re; v.stall = st;
    v.rxv = rxv; v.rxd = rxd; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(rx_q.size() != 0) | (32'(tx_q.size() < DEPTH) << 1) | (32'(m_ovf) << 2)
      | (32'(rx_q.size()) << 8) | (32'(tx_q.size()) << 16);
    return s;
  endfunction

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_ovf = 1'b0;
    m_rd  = '0;
    m_cnt = '0;
  endtask

  task automatic check_outputs();
    check("rd_data", rd_data, m_rd);
    check("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
    if (tx_q.size() != 0) check("tx_data", 32'(tx_data), 32'(tx_q[0]));
    check("rx_ready", 32'(rx_ready), 32'(rx_q.size() < DEPTH));
  endtask

  // One clock cycle: drive, update the model from pre-edge state, compare after the edge.
  task automatic step(input logic [31:0] a, input logic [7:0] wd, input logic we,
                      input logic re, input logic st, input logic txr, input logic rxv,
                      input logic [7:0] rxd);
    bit sel, tx_pop, rx_push, rx_pop, flush, acc;
    logic [7:0] off;
    req_addr = a; req_wdata = wd; req_we = we; req_re = re; stall = st;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;

    sel = (a[31:28] == 4'h8) && !st;
    off = a[7:0];
    if (sel && re) begin
      case (off)
        8'h00: m_rd = m_status();
        8'h04: m_rd = (rx_q.size() != 0) ? {24'd0, rx_q[0]} : 32'd0;
`ifdef UART_MMIO_CYCLE_CNT_EN
        8'h10: m_rd = m_cnt;
`endif
        default: m_rd = 32'd0;
      endcase
    end else if (!st) begin
      m_rd = 32'd0;
    end

    tx_pop  = (tx_q.size() != 0) && txr;
    rx_push = rxv && (rx_q.size() < DEPTH);
    rx_pop  = sel && re && (off == 8'h04) && (rx_q.size() != 0);
    flush   = sel && we && (off == 8'h0C) && wd[0];
    acc     = 1'b0;
    if (sel && we && off == 8'h08) begin
      if (tx_q.size() < DEPTH || tx_pop) acc = 1'b1;
      else m_ovf = 1'b1;
    end
    if (sel && we && off == 8'h0C && wd[1]) m_ovf = 1'b0;

    if (flush) begin
      tx_q.delete();
      rx_q.delete();
    end else begin
      if (tx_pop) void'(tx_q.pop_front());
      if (acc) tx_q.push_back(wd);
      if (rx_pop) void'(rx_q.pop_front());
      if (rx_push) rx_q.push_back(rxd);
    end

    if (sel && we && off == 8'h14) m_cnt = '0;
    else m_cnt = m_cnt + 32'd1;

    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic txr);
    step(32'h0, 8'h00, 1'b0, 1'b0, 1'b0, txr, 1'b0, 8'h00);
  endtask

  task automatic cpu_rd(input logic [31:0] a, input logic txr);
    step(a, 8'h00, 1'b0, 1'b1, 1'b0, txr, 1'b0, 8'h00);
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [7:0] wd, input logic txr);
    step(a, wd, 1'b1, 1'b0, 1'b0, txr, 1'b0, 8'h00);
  endtask

  task automatic uart_rx(input logic [7:0] b);
    step(32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, b);
  endtask

  // Drain TX with tx_ready high, recording every byte the UART accepts.
  task automatic drain();
    got_q.delete();
    for (int i = 0; i < 20; i++) begin
      if (!tx_valid) break;
      got_q.push_back(tx_data);
      idle(1'b1);
    end
    check("drain_done", 32'(tx_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_we = 1'b0; req_re = 1'b0; stall = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  wd;
    logic        we, re;
    int          k;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("reset_rd", rd_data, 32'd0);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_rx_ready", 32'(rx_ready), 32'd1);

    // Directed table
    vecs.push_back(mkv(32'h8000_0000, 8'h00, 0, 1, 0, 0, 8'h00, 32'h0000_0002));
    vecs.push_back(mkv(32'h0000_0000, 8'h00, 0, 0, 0, 1, 8'h5A, 32'h0000_0000));
    vecs.push_back(mkv(32'h0000_0000, 8'h00, 0, 0, 0, 1, 8'hA5, 32'h0000_0000));
    vecs.push_back(mkv(32'h8000_0000, 8'h00, 0, 1, 0, 0, 8'h00, 32'h0000_0203));
    vecs.push_back(mkv(32'h8000_0004, 8'h00, 0, 1, 0, 0, 8'h00, 32'h0000_005A));
    vecs.push_back(mkv(32'h8000_0004, 8'h00, 0, 1, 0, 0, 8'h00, 32'h0000_00A5));
    vecs.push_back(mkv(32'h8000_0004, 8'h00, 0, 1, 0, 0, 8'h00, 32'h0000_0000));
    vecs.push_back(mkv(32'h8000_0000, 8'h00, 0, 1, 0, 0, 8'h00, 32'h0000_0002));
    vecs.push_back(mkv(32'h8000_0020, 8'h00, 0, 1, 0, 0, 8'h00, 32'h0000_0000));
    vecs.push_back(mkv(32'h4000_0000, 8'h00, 0, 1, 0, 0, 8'h00, 32'h0000_0000));
    vecs.push_back(mkv(32'h0000_0000, 8'h00, 0, 0, 0, 1, 8'h33, 32'h0000_0000));
    vecs.push_back(mkv(32'h8000_0000, 8'h00, 0, 1, 0, 0, 8'h00, 32'h0000_0103));
    vecs.push_back(mkv(32'h8000_0004, 8'h00, 0, 1, 1, 0, 8'h00, 32'h0000_0103));
    vecs.push_back(mkv(32'h8000_0000, 8'h00, 0, 1, 0, 0, 8'h00, 32'h0000_0103));
    vecs.push_back(mkv(32'h8000_0004, 8'h00, 0, 1, 0, 0, 8'h00, 32'h0000_0033));
    vecs.push_back(mkv(32'h8000_0000, 8'h00, 0, 1, 0, 0, 8'h00, 32'h0000_0002));
    foreach (vecs[i]) begin
      step(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re, vecs[i].stall, 1'b0,
           vecs[i].rxv, vecs[i].rxd);
      check($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
    end

    // TX overflow: 9 stores with the UART stalled
    for (int i = 0; i < 9; i++) cpu_wr(32'h8000_0008, 8'h41 + 8'(i), 1'b0);
    cpu_rd(32'h8000_0000, 1'b0);
    check("ovf_status", rd_data, 32'h0008_0004);
    drain();
    check("ovf_drain_cnt", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < got_q.size() && i < 8; i++)
      check($sformatf("ovf_byte%0d", i), 32'(got_q[i]), 32'h41 + 32'(i));
    cpu_wr(32'h8000_000C, 8'h02, 1'b0);
    cpu_rd(32'h8000_0000, 1'b0);
    check("ovf_clear", rd_data, 32'h0000_0002);

    // Full TX with simultaneous UART drain and CPU store
    for (int i = 0; i < 8; i++) cpu_wr(32'h8000_0008, 8'h61 + 8'(i), 1'b0);
    cpu_wr(32'h8000_0008, 8'h77, 1'b1);
    cpu_rd(32'h8000_0000, 1'b0);
    check("full_wr_status", rd_data, 32'h0008_0000);
    drain();
    check("full_wr_cnt", 32'(got_q.size()), 32'd8);
    if (got_q.size() != 0) check("full_wr_last", 32'(got_q[got_q.size()-1]), 32'h77);

    // Flush with a same-cycle UART push
    cpu_wr(32'h8000_0008, 8'h11, 1'b0);
    uart_rx(8'h22);
    step(32'h8000_000C, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33);
    cpu_rd(32'h8000_0000, 1'b0);
    check("flush_status", rd_data, 32'h0000_0002);

    // Empty RX: CPU pop and UART push together
    step(32'h8000_0004, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
    check("rx_empty_pop", rd_data, 32'h0);
    cpu_rd(32'h8000_0000, 1'b0);
    check("rx_push_kept", rd_data, 32'h0000_0103);
    cpu_rd(32'h8000_0004, 1'b0);
    check("rx_push_data", rd_data, 32'h99);

    // RX full: ninth byte refused
    for (int i = 0; i < 9; i++) uart_rx(8'hB0 + 8'(i));
    check("rx_full_ready", 32'(rx_ready), 32'd0);
    cpu_rd(32'h8000_0000, 1'b0);
    check("rx_full_status", rd_data, 32'h0000_0803);
    for (int i = 0; i < 8; i++) begin
      cpu_rd(32'h8000_0004, 1'b0);
      check($sformatf("rx_full_pop%0d", i), rd_data, 32'hB0 + 32'(i));
    end

    // Reset mid-transfer
    cpu_wr(32'h8000_0008, 8'hC1, 1'b0);
    cpu_wr(32'h8000_0008, 8'hC2, 1'b0);
    uart_rx(8'hC3);
    cpu_rd(32'h8000_0000, 1'b0);
    do_reset();
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_rx_ready", 32'(rx_ready), 32'd1);
    check("midrst_rd", rd_data, 32'd0);
    cpu_rd(32'h8000_0000, 1'b0);
    check("midrst_status", rd_data, 32'h0000_0002);

    // Cycle counter
    cpu_wr(32'h8000_0014, 8'h00, 1'b0);
    repeat (10) idle(1'b0);
    cpu_rd(32'h8000_0010, 1'b0);
`ifdef UART_MMIO_CYCLE_CNT_EN
    check("cycle_cnt", rd_data, 32'd10);
`else
    check("cycle_cnt_absent", rd_data, 32'd0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 7);
      case (k)
        0: a = 32'h8000_0000;
        1: a = 32'h8000_0004;
        2: a = 32'h8000_0008;
        3: a = 32'h8000_000C;
        4: a = 32'h8000_0010;
        5: a = 32'h8000_0014;
        6: a = 32'h8000_0020;
        default: a = 32'h4000_0004;
      endcase
      we = (k == 2 || k == 3 || k == 5) ? ($urandom_range(0, 1) == 1) : 1'b0;
      re = !we && ($urandom_range(0, 2) != 0);
      wd = 8'($urandom);
      if (k == 3) wd = ($urandom_range(0, 19) == 0) ? 8'h01 : 8'h02;
      step(a, wd, we, re, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3,
           $urandom_range(0, 1) == 1, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
